btn_ctrl_bank: RTL and testbench
================================

BTN_CTRL_BANK -- requirements
Module: btn_ctrl_bank

Interface
REQ-001 The block SHALL have parameter N_BTN, default 4: number of independent button channels.
REQ-002 The block SHALL have parameter DB_W, default 20: debounce counter width; the debounce window is 2^DB_W cycles.
REQ-003 The block SHALL have parameter LONG_W, default 26: long-press counter width; the long-press threshold is 2^LONG_W-1 cycles.
REQ-004 The block SHALL have parameter SEL_W, default 2: per-channel selection counter width.
REQ-005 The block SHALL have port ILA_clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port btn_in, input, N_BTN bits: raw asynchronous push-button levels, 1 = pressed.
REQ-008 The block SHALL have port mod_i, input, N_BTN*SEL_W bits: per-channel counter modulus; channel i uses slice [i*SEL_W +: SEL_W]; 0 = full 2^SEL_W range.
REQ-009 The block SHALL have port stable_o, output, N_BTN bits: debounced button level.
REQ-010 The block SHALL have port press_p, output, N_BTN bits: one-cycle pulse per debounced press.
REQ-011 The block SHALL have port long_p, output, N_BTN bits: one-cycle pulse per long hold.
REQ-012 The block SHALL have port sel_o, output, N_BTN*SEL_W bits: per-channel selection counters, same slicing as mod_i.

Function
REQ-013 Each btn_in bit SHALL pass through a 2-flop synchronizer; only the second-stage value (sync) drives further logic.
REQ-014 Each channel SHALL own its debounce counter: reset to 0 when sync == stable, increment when sync != stable; when it equals 2^DB_W-1 with sync != stable, stable <= sync and the counter <= 0.
REQ-015 stable_o SHALL therefore change only after 2^DB_W consecutive disagreeing cycles; a shorter glitch SHALL produce no change and no pulse.
REQ-016 press_p[i] SHALL be high for exactly one cycle: the cycle after stable_o[i] goes 0->1; a release SHALL produce no pulse.
REQ-017 A per-channel hold counter SHALL increment while stable_o[i]=1, saturate at 2^LONG_W-1, and clear to 0 when stable_o[i]=0.
REQ-018 long_p[i] SHALL pulse for one cycle when the hold counter first reaches saturation, and SHALL pulse at most once per press.
REQ-019 On press_p[i], sel[i] SHALL load 0 if sel[i] >= M-1, else sel[i]+1, where M = mod slice (M=0 means 2^SEL_W; M=1 holds sel at 0).
REQ-020 On long_p[i], sel[i] SHALL clear to 0. press_p and long_p cannot coincide in one channel; if forced, clear wins.
REQ-021 If mod_i changes so that sel >= M, sel SHALL hold until the next press, then wrap to 0 (per REQ-019).
REQ-022 Channels SHALL be fully independent; simultaneous events on different channels SHALL each be handled in the same cycle.

Reset
REQ-023 While rstn=0, synchronizers, debounce counters, hold counters, stable_o, press_p, long_p and sel_o SHALL all be 0.
REQ-024 A button held through reset release SHALL be treated as a new press: press_p follows after 2+2^DB_W cycles.
REQ-025 Assertion of rstn mid-debounce or mid-hold SHALL abort that operation with no pulse emitted.

Structure
REQ-026 A package btn_ctrl_pkg SHALL hold the default values of N_BTN, DB_W, LONG_W and SEL_W and the saturation constants derived from them.
REQ-027 Per-channel logic SHALL live in sub-module btn_chan, instantiated N_BTN times by generate in btn_ctrl_bank; btn_ctrl_bank contains only slicing and instantiation.

Verification (DB_W=4, LONG_W=6, SEL_W=2, N_BTN=4)
REQ-028 The bench SHALL check debounce: btn_in[0] high for 10 cycles -> stable_o, press_p and sel_o stay 0; held 20 cycles -> stable_o[0]=1 exactly 18 cycles after the input change and one press_p[0] pulse.
REQ-029 The bench SHALL check wrap: mod slice 0 = 3, four debounced presses -> sel_o[1:0] sequence 1,2,0,1; mod slice = 0 -> 1,2,3,0.
REQ-030 The bench SHALL check long press: hold btn_in[1] for 100 cycles -> exactly one long_p[1] pulse, 63 cycles after stable_o[1] rises, and sel slice 1 cleared to 0.
REQ-031 The bench SHALL check concurrency: btn_in[2] and btn_in[3] rise in the same cycle -> press_p[2] and press_p[3] pulse in the same cycle and both counters increment.
REQ-032 The bench SHALL check reset: rstn low 8 cycles after the press begins, then released with the button still held -> all outputs 0 during reset; press_p pulses 18 cycles after release and sel=1.
REQ-033 The bench SHALL check modulus shrink: sel=3, mod changed to 2 -> sel holds 3; next press -> sel=0.

Source files
------------

// File: rtl/btn_ctrl_pkg.sv
// Shared defaults for the push-button control bank.
//   N_BTN_DEF    : number of button channels
//   DB_W_DEF     : debounce counter width (window = 2^DB_W cycles)
//   LONG_W_DEF   : long-press counter width (threshold = 2^LONG_W-1 cycles)
//   SEL_W_DEF    : selection counter width
//   *_MAX_DEF    : saturation values derived from the widths above
package btn_ctrl_pkg;

  localparam int unsigned N_BTN_DEF  = 4;
  localparam int unsigned DB_W_DEF   = 20;
  localparam int unsigned LONG_W_DEF = 26;
  localparam int unsigned SEL_W_DEF  = 2;

  localparam int unsigned DB_MAX_DEF   = (1 << DB_W_DEF) - 1;
  localparam int unsigned LONG_MAX_DEF = (1 << LONG_W_DEF) - 1;
  localparam int unsigned SEL_MAX_DEF  = (1 << SEL_W_DEF) - 1;

endpackage

// File: rtl/btn_chan.sv
// One push-button channel: 2-flop synchronizer, debouncer, press / long-press
// pulse generation and a modulo selection counter.
//   ILA_clk  : clock, rising edge
//   rstn     : asynchronous active-low reset
//   btn_i    : raw button level (1 = pressed)
//   mod_i    : selection modulus, 0 = full 2^SEL_W range
//   stable_o : debounced level
//   press_o  : one-cycle pulse on debounced press
//   long_o   : one-cycle pulse when a hold reaches the long-press threshold
//   sel_o    : selection counter
module btn_chan
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned DB_W   = DB_W_DEF,
  parameter int unsigned LONG_W = LONG_W_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF
) (
  input  logic             ILA_clk,
  input  logic             rstn,
  input  logic             btn_i,
  input  logic [SEL_W-1:0] mod_i,
  output logic             stable_o,
  output logic             press_o,
  output logic             long_o,
  output logic [SEL_W-1:0] sel_o
);

  localparam logic [DB_W-1:0]   DbMax   = '1;
  localparam logic [LONG_W-1:0] LongMax = '1;
  localparam logic [SEL_W:0]    FullMod = {1'b1, {SEL_W{1'b0}}};

  logic              meta_q, sync_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              stable_q, stable_d;
  logic [LONG_W-1:0] hold_q, hold_d;
  logic              press_q, press_d;
  logic              long_q, long_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W:0]    mod_full;
  logic [SEL_W:0]    sel_inc;

  always_comb begin
    // Debounce: count consecutive cycles where the synchronized input
    // disagrees with the accepted level; any agreement restarts the window.
    db_cnt_d = '0;
    stable_d = stable_q;
    if (sync_q != stable_q) begin
      if (db_cnt_q == DbMax) begin
        stable_d = sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    hold_d = '0;
    if (stable_q) begin
      hold_d = (hold_q == LongMax) ? hold_q : hold_q + 1'b1;
    end

    press_d = stable_d & ~stable_q;
    // Fires only on the transition into saturation, so once per press.
    long_d  = (hold_d == LongMax) && (hold_q != LongMax);

    mod_full = (mod_i == '0) ? FullMod : {1'b0, mod_i};
    sel_inc  = {1'b0, sel_q} + 1'b1;
    sel_d    = sel_q;
    if (long_q) begin
      sel_d = '0;
    end else if (press_q) begin
      // Also wraps a value left out of range by a shrunk modulus.
      sel_d = (sel_inc >= mod_full) ? '0 : sel_inc[SEL_W-1:0];
    end
  end

  always_ff @(posedge ILA_clk or negedge rstn) begin
    if (!rstn) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      db_cnt_q <= '0;
      stable_q <= 1'b0;
      hold_q   <= '0;
      press_q  <= 1'b0;
      long_q   <= 1'b0;
      sel_q    <= '0;
    end else begin
      meta_q   <= btn_i;
      sync_q   <= meta_q;
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
      hold_q   <= hold_d;
      press_q  <= press_d;
      long_q   <= long_d;
      sel_q    <= sel_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;
  assign long_o   = long_q;
  assign sel_o    = sel_q;

endmodule

// File: rtl/btn_ctrl_bank.sv
// Bank of N_BTN independent push-button channels.
//   ILA_clk  : clock, rising edge
//   rstn     : asynchronous active-low reset
//   btn_in   : raw button levels, 1 = pressed
//   mod_i    : per-channel modulus, channel i at [i*SEL_W +: SEL_W]
//   stable_o : debounced levels
//   press_p  : one-cycle press pulses
//   long_p   : one-cycle long-hold pulses
//   sel_o    : per-channel selection counters, sliced as mod_i
module btn_ctrl_bank
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned N_BTN  = N_BTN_DEF,
  parameter int unsigned DB_W   = DB_W_DEF,
  parameter int unsigned LONG_W = LONG_W_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF
) (
  input  logic                   ILA_clk,
  input  logic                   rstn,
  input  logic [N_BTN-1:0]       btn_in,
  input  logic [N_BTN*SEL_W-1:0] mod_i,
  output logic [N_BTN-1:0]       stable_o,
  output logic [N_BTN-1:0]       press_p,
  output logic [N_BTN-1:0]       long_p,
  output logic [N_BTN*SEL_W-1:0] sel_o
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .DB_W  (DB_W),
      .LONG_W(LONG_W),
      .SEL_W (SEL_W)
    ) u_chan (
      .ILA_clk (ILA_clk),
      .rstn    (rstn),
      .btn_i   (btn_in[i]),
      .mod_i   (mod_i[i*SEL_W +: SEL_W]),
      .stable_o(stable_o[i]),
      .press_o (press_p[i]),
      .long_o  (long_p[i]),
      .sel_o   (sel_o[i*SEL_W +: SEL_W])
    );
  end

endmodule

// File: tb/tb_btn_ctrl_bank.sv
// Directed bench for btn_ctrl_bank with short counters (DB_W=4, LONG_W=6).
module tb_btn_ctrl_bank;

  localparam int unsigned N_BTN  = 4;
  localparam int unsigned DB_W   = 4;
  localparam int unsigned LONG_W = 6;
  localparam int unsigned SEL_W  = 2;

  logic                   ILA_clk = 1'b0;
  logic                   rstn    = 1'b0;
  logic [N_BTN-1:0]       btn_in  = '0;
  logic [N_BTN*SEL_W-1:0] mod_i   = '0;
  logic [N_BTN-1:0]       stable_o;
  logic [N_BTN-1:0]       press_p;
  logic [N_BTN-1:0]       long_p;
  logic [N_BTN*SEL_W-1:0] sel_o;

  int n_tests = 0;
  int n_fail  = 0;

  btn_ctrl_bank #(
    .N_BTN (N_BTN),
    .DB_W  (DB_W),
    .LONG_W(LONG_W),
    .SEL_W (SEL_W)
  ) dut (
    .ILA_clk (ILA_clk),
    .rstn    (rstn),
    .btn_in  (btn_in),
    .mod_i   (mod_i),
    .stable_o(stable_o),
    .press_p (press_p),
    .long_p  (long_p),
    .sel_o   (sel_o)
  );

  always #5 ILA_clk = ~ILA_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive just after the rising edge.
  task automatic step();
    @(posedge ILA_clk);
    #1;
  endtask

  function automatic logic [SEL_W-1:0] sel_at(input int ch);
    return sel_o[ch*SEL_W +: SEL_W];
  endfunction

  // Raise btn_in[ch], drop it after 'hold' cycles, observe 'total' cycles.
  // Step numbers count rising edges since the input change.
  task automatic hold_watch(input int ch, input int hold, input int total,
                            output int rise, output int press_at, output int n_press,
                            output int long_at, output int n_long);
    rise = 0; press_at = 0; n_press = 0; long_at = 0; n_long = 0;
    btn_in[ch] = 1'b1;
    for (int k = 1; k <= total; k++) begin
      step();
      if (rise == 0 && stable_o[ch]) rise = k;
      if (press_p[ch]) begin n_press++; press_at = k; end
      if (long_p[ch]) begin n_long++; long_at = k; end
      if (k == hold) btn_in[ch] = 1'b0;
    end
  endtask

  task automatic press(input int ch, input int exp_sel, input string tag);
    int r, pa, np, la, nl;
    hold_watch(ch, 20, 45, r, pa, np, la, nl);
    check({tag, "_npress"}, np, 1);
    check({tag, "_sel"}, sel_at(ch), exp_sel);
  endtask

  initial begin
    int r, pa, np, la, nl;
    int pa2, pa3;

    // Reset state
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_stable", stable_o, 0);
      check("rst_press", press_p, 0);
      check("rst_long", long_p, 0);
      check("rst_sel", sel_o, 0);
    end
    rstn = 1'b1;
    step(); step();

    // Debounce: short glitch is ignored, real press accepted at step 18
    mod_i[1:0] = 2'd1;
    hold_watch(0, 10, 40, r, pa, np, la, nl);
    check("glitch_rise", r, 0);
    check("glitch_npress", np, 0);
    check("glitch_sel", sel_at(0), 0);
    hold_watch(0, 20, 50, r, pa, np, la, nl);
    check("db_rise", r, 18);
    check("db_press_at", pa, 18);
    check("db_npress", np, 1);
    check("db_nlong", nl, 0);
    check("db_sel_mod1", sel_at(0), 0);
    check("db_stable_end", stable_o[0], 0);

    // Wrap with modulus 3, then full range
    mod_i[1:0] = 2'd3;
    press(0, 1, "m3_a");
    press(0, 2, "m3_b");
    press(0, 0, "m3_c");
    press(0, 1, "m3_d");
    mod_i[1:0] = 2'd1;
    press(0, 0, "m1");
    mod_i[1:0] = 2'd0;
    press(0, 1, "m0_a");
    press(0, 2, "m0_b");
    press(0, 3, "m0_c");
    press(0, 0, "m0_d");

    // Long press on channel 1
    press(1, 1, "lp_pre");
    hold_watch(1, 100, 150, r, pa, np, la, nl);
    check("lp_rise", r, 18);
    check("lp_npress", np, 1);
    check("lp_long_at", la, 81);
    check("lp_nlong", nl, 1);
    check("lp_sel", sel_at(1), 0);
    check("lp_other_sel", sel_at(0), 0);

    // Concurrent presses on channels 2 and 3
    pa2 = 0; pa3 = 0;
    btn_in[3:2] = 2'b11;
    for (int k = 1; k <= 45; k++) begin
      step();
      if (press_p[2]) pa2 = k;
      if (press_p[3]) pa3 = k;
      if (k == 20) btn_in[3:2] = 2'b00;
    end
    check("cc_press2_at", pa2, 18);
    check("cc_press3_at", pa3, 18);
    check("cc_sel2", sel_at(2), 1);
    check("cc_sel3", sel_at(3), 1);

    // Reset mid-debounce with the button held through release
    np = 0;
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (press_p[0]) np++;
    end
    check("rs_pre_npress", np, 0);
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rs_stable", stable_o, 0);
      check("rs_press", press_p, 0);
      check("rs_long", long_p, 0);
      check("rs_sel", sel_o, 0);
    end
    rstn = 1'b1;
    hold_watch(0, 20, 45, r, pa, np, la, nl);
    check("rs_press_at", pa, 18);
    check("rs_npress", np, 1);
    check("rs_sel", sel_at(0), 1);

    // Modulus shrink below the current selection
    press(0, 2, "sh_a");
    press(0, 3, "sh_b");
    mod_i[1:0] = 2'd2;
    for (int k = 0; k < 5; k++) step();
    check("sh_hold", sel_at(0), 3);
    press(0, 0, "sh_wrap");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
